// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin sharing of one adder among three step counters,
// with per-channel clear, global pause and sticky overflow flags.
module counter_arbiter #(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [3*STEP_W-1:0]   step,
  input  logic [2:0]            clr,
  input  logic                  pause,
  output logic [2:0]            ack,
  output logic [WIDTH-1:0]      count0,
  output logic [WIDTH-1:0]      count1,
  output logic [WIDTH-1:0]      count2,
  output logic [2:0]            ovf,
  output logic [1:0]            last_grant
);
  logic [WIDTH-1:0] cnt_q [3];
  logic [WIDTH-1:0] cnt_d [3];
  logic [WIDTH-1:0] sel;
  logic [2:0]       ack_q, ack_d, ovf_q, ovf_d, elig;
  logic [1:0]       lg_q, lg_d, p0, p1, g;
  logic             gnt;
  logic [STEP_W-1:0] stp;
  logic [WIDTH:0]   sum;
  always_comb begin
    elig  = req & ~ack_q & ~clr;
    p0    = lg_q == 2'd2 ? 2'd0 : lg_q + 2'd1;
    p1    = p0 == 2'd2 ? 2'd0 : p0 + 2'd1;
    g     = elig[p0] ? p0 : elig[p1] ? p1 : lg_q;
    gnt   = !pause && |elig;
    stp   = step[int'(g)*STEP_W +: STEP_W];
    sel   = g == 2'd0 ? cnt_q[0] : g == 2'd1 ? cnt_q[1] : cnt_q[2];
    sum   = {1'b0, sel} + {{(WIDTH+1-STEP_W){1'b0}}, stp};
    ack_d = gnt ? 3'b001 << g : 3'b000;
    lg_d  = gnt ? g : lg_q;
    ovf_d = (ovf_q & ~clr) | (sum[WIDTH] ? ack_d : 3'b000);
    for (int i = 0; i < 3; i++)
      cnt_d[i] = clr[i] ? '0 : !ack_d[i] ? cnt_q[i] :
                 (sum[WIDTH] && SATURATE != 0) ? '1 : sum[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '{default: '0};
      ack_q <= '0;
      ovf_q <= '0;
      lg_q  <= 2'd2;
    end else begin
      cnt_q <= cnt_d;
      ack_q <= ack_d;
      ovf_q <= ovf_d;
      lg_q  <= lg_d;
    end
  end
  assign ack        = ack_q;
  assign ovf        = ovf_q;
  assign last_grant = lg_q;
  assign count0     = cnt_q[0];
  assign count1     = cnt_q[1];
  assign count2     = cnt_q[2];
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: wrap and saturate instances driven in lockstep against a behavioural model.
module tb_counter_arbiter;
  logic clk = 0, reset = 1, pause = 0;
  logic [2:0] req = 0, clr = 0;
  logic [11:0] step = 0;
  logic [2:0] ack_w, ack_s, ovf_w, ovf_s;
  logic [1:0] lg_w, lg_s;
  logic [2:0][7:0] cw, cs;
  int n_vec = 0, n_err = 0;
  int m_cnt [2][3];
  logic [2:0] m_ovf [2];
  logic [2:0] m_ack;
  int m_lg;

  always #5 clk = ~clk;

  counter_arbiter #(.WIDTH(8), .STEP_W(4), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .req(req), .step(step), .clr(clr), .pause(pause),
    .ack(ack_w), .count0(cw[0]), .count1(cw[1]), .count2(cw[2]), .ovf(ovf_w), .last_grant(lg_w));
  counter_arbiter #(.WIDTH(8), .STEP_W(4), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .req(req), .step(step), .clr(clr), .pause(pause),
    .ack(ack_s), .count0(cs[0]), .count1(cs[1]), .count2(cs[2]), .ovf(ovf_s), .last_grant(lg_s));

  // Drive one cycle of inputs, advance the model to the post-edge state, then sample.
  task automatic apply(input logic [2:0] r, input logic [11:0] s, input logic [2:0] c,
                       input logic p, input logic rs);
    int g, ch, sm;
    logic [2:0] el;
    @(negedge clk);
    req = r; step = s; clr = c; pause = p; reset = rs;
    if (rs) begin
      for (int v = 0; v < 2; v++) begin
        for (int i = 0; i < 3; i++) m_cnt[v][i] = 0;
        m_ovf[v] = 0;
      end
      m_ack = 0;
      m_lg = 2;
    end else begin
      el = r & ~m_ack & ~c;
      g = -1;
      if (!p)
        for (int k = 1; k <= 3; k++) begin
          ch = (m_lg + k) % 3;
          if (g < 0 && el[ch]) g = ch;
        end
      for (int i = 0; i < 3; i++)
        if (c[i]) for (int v = 0; v < 2; v++) begin m_cnt[v][i] = 0; m_ovf[v][i] = 1'b0; end
      m_ack = 0;
      if (g >= 0) begin
        for (int v = 0; v < 2; v++) begin
          sm = m_cnt[v][g] + int'(s[g*4 +: 4]);
          if (sm > 255) m_ovf[v][g] = 1'b1;
          m_cnt[v][g] = sm <= 255 ? sm : (v == 0 ? sm - 256 : 255);
        end
        m_ack[g] = 1'b1;
        m_lg = g;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    apply(0, 0, 0, 0, 1);
    apply(3'b111, 12'hfff, 0, 0, 1);
    n_vec++;
    if (ack_w !== 3'b000 || ack_s !== 3'b000) begin n_err++; $display("FAIL reset_ack got %b/%b exp 000", ack_w, ack_s); end
    n_vec++;
    if (cw !== '0 || cs !== '0) begin n_err++; $display("FAIL reset_count got %h/%h exp 0", cw, cs); end
    n_vec++;
    if (ovf_w !== 3'b000 || ovf_s !== 3'b000) begin n_err++; $display("FAIL reset_ovf got %b/%b exp 000", ovf_w, ovf_s); end
    n_vec++;
    if (lg_w !== 2'd2 || lg_s !== 2'd2) begin n_err++; $display("FAIL reset_last_grant got %0d/%0d exp 2", lg_w, lg_s); end
  endtask

  task automatic test_rotation;
    logic [2:0] exp_ack [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    apply(0, 0, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      apply(3'b111, {4'd3, 4'd2, 4'd1}, 0, 0, 0);
      n_vec++;
      if (ack_w !== exp_ack[k]) begin n_err++; $display("FAIL rot_ack[%0d] got %b exp %b", k, ack_w, exp_ack[k]); end
    end
    n_vec++;
    if (cw[0] !== 8'd2 || cw[1] !== 8'd4 || cw[2] !== 8'd6) begin
      n_err++; $display("FAIL rot_counts got %0d,%0d,%0d exp 2,4,6", cw[0], cw[1], cw[2]);
    end
  endtask

  task automatic test_single;
    int pulses = 0;
    apply(0, 0, 0, 0, 1);
    for (int k = 0; k < 10; k++) begin
      apply(3'b010, {4'd0, 4'd5, 4'd0}, 0, 0, 0);
      pulses += int'(ack_w[1]);
      n_vec++;
      if (ack_w !== (k % 2 == 0 ? 3'b010 : 3'b000)) begin n_err++; $display("FAIL single_ack[%0d] got %b", k, ack_w); end
    end
    n_vec++;
    if (pulses != 5 || cw[1] !== 8'd25 || lg_w !== 2'd1) begin
      n_err++; $display("FAIL single_total got pulses=%0d count1=%0d lg=%0d exp 5,25,1", pulses, cw[1], lg_w);
    end
  endtask

  task automatic test_overflow;
    apply(0, 0, 0, 0, 1);
    for (int k = 0; k < 50; k++) apply(3'b001, 12'd10, 0, 0, 0);
    n_vec++;
    if (cw[0] !== 8'd250 || cs[0] !== 8'd250) begin n_err++; $display("FAIL ovf_preload got %0d/%0d exp 250", cw[0], cs[0]); end
    apply(3'b001, 12'd15, 0, 0, 0);
    n_vec++;
    if (ack_w !== 3'b001 || cw[0] !== 8'd9 || ovf_w[0] !== 1'b1) begin
      n_err++; $display("FAIL ovf_wrap got ack=%b count0=%0d ovf=%b exp 001,9,1", ack_w, cw[0], ovf_w);
    end
    n_vec++;
    if (cs[0] !== 8'd255 || ovf_s[0] !== 1'b1) begin
      n_err++; $display("FAIL ovf_sat got count0=%0d ovf=%b exp 255,1", cs[0], ovf_s);
    end
    apply(0, 0, 3'b001, 0, 0);
    n_vec++;
    if (cw[0] !== 8'd0 || cs[0] !== 8'd0 || ovf_w !== 3'b000 || ovf_s !== 3'b000) begin
      n_err++; $display("FAIL ovf_clear got %0d/%0d ovf %b/%b exp 0", cw[0], cs[0], ovf_w, ovf_s);
    end
  endtask

  task automatic test_pause_clear;
    apply(0, 0, 0, 0, 1);
    apply(3'b110, {4'd3, 4'd4, 4'd0}, 0, 0, 0);
    apply(3'b110, {4'd3, 4'd4, 4'd0}, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      apply(3'b110, {4'd3, 4'd4, 4'd0}, 0, 1, 0);
      n_vec++;
      if (ack_w !== 3'b000 || cw[1] !== 8'd4 || cw[2] !== 8'd3) begin
        n_err++; $display("FAIL pause[%0d] got ack=%b c1=%0d c2=%0d exp 000,4,3", k, ack_w, cw[1], cw[2]);
      end
    end
    apply(3'b110, {4'd3, 4'd4, 4'd0}, 3'b010, 0, 0);
    n_vec++;
    if (ack_w !== 3'b100 || cw[1] !== 8'd0 || cw[2] !== 8'd6) begin
      n_err++; $display("FAIL pause_release got ack=%b c1=%0d c2=%0d exp 100,0,6", ack_w, cw[1], cw[2]);
    end
  endtask

  task automatic test_reset_mid;
    apply(0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) apply(3'b111, 12'h111, 0, 0, 0);
    apply(3'b111, 12'h111, 0, 0, 1);
    n_vec++;
    if (ack_w !== 3'b000 || cw !== '0 || ovf_w !== 3'b000 || lg_w !== 2'd2) begin
      n_err++; $display("FAIL mid_reset got ack=%b counts=%h ovf=%b lg=%0d", ack_w, cw, ovf_w, lg_w);
    end
    apply(3'b111, 12'h111, 0, 0, 0);
    n_vec++;
    if (ack_w !== 3'b001) begin n_err++; $display("FAIL mid_reset_next got %b exp 001", ack_w); end
  endtask

  task automatic test_random;
    apply(0, 0, 0, 0, 1);
    for (int n = 0; n < 400; n++) begin
      apply(3'($urandom), 12'($urandom),
            {$urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0},
            $urandom_range(5) == 0, $urandom_range(39) == 0);
      n_vec++;
      if (ack_w !== m_ack || ack_s !== m_ack) begin
        n_err++; $display("FAIL rand_ack[%0d] got %b/%b exp %b", n, ack_w, ack_s, m_ack);
      end
      n_vec++;
      if (lg_w !== 2'(m_lg) || lg_s !== 2'(m_lg)) begin
        n_err++; $display("FAIL rand_last_grant[%0d] got %0d/%0d exp %0d", n, lg_w, lg_s, m_lg);
      end
      n_vec++;
      if (ovf_w !== m_ovf[0] || ovf_s !== m_ovf[1]) begin
        n_err++; $display("FAIL rand_ovf[%0d] got %b/%b exp %b/%b", n, ovf_w, ovf_s, m_ovf[0], m_ovf[1]);
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (cw[i] !== 8'(m_cnt[0][i]) || cs[i] !== 8'(m_cnt[1][i])) begin
          n_err++; $display("FAIL rand_count%0d[%0d] got %0d/%0d exp %0d/%0d", i, n, cw[i], cs[i], m_cnt[0][i], m_cnt[1][i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_rotation;
    test_single;
    test_overflow;
    test_pause_clear;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares one 8-bit adder among three counter channels (count0, count1, count2) in the counter datapath driven by tb_top. Each channel raises a level request with a step value. The block grants at most one channel per cycle, applies the step to that channel's counter and returns a one-cycle acknowledge. It also provides per-channel synchronous clear, a global pause, and sticky overflow flags.

## Interface
- WIDTH, 8, counter width in bits
- STEP_W, 4, per-channel step width in bits
- SATURATE, 0, overflow behaviour: 0 = wrap modulo 2^WIDTH; 1 = clamp at 2^WIDTH-1

- clk  in  1  sole clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req  in  3  per-channel increment request, level; bit i = channel i
- step  in  3*STEP_W  packed steps; channel i = step[i*STEP_W +: STEP_W], sampled in the grant cycle
- clr  in  3  per-channel synchronous clear
- pause  in  1  when high, no grants; requests stay pending
- ack  out  3  one-hot registered acknowledge, one cycle per served request
- count0  out  WIDTH  channel 0 counter
- count1  out  WIDTH  channel 1 counter
- count2  out  WIDTH  channel 2 counter
- ovf  out  3  sticky per-channel overflow flag
- last_grant  out  2  index of the most recently granted channel (0..2)

## Operation
- Reset, sampled on an edge with reset=1:
  - count0/1/2 = 0, ack = 0, ovf = 0.
  - last_grant = 2, so channel 0 has first priority after reset.
  - Reset overrides every other input.
- Eligible set in cycle t: req & ~ack & ~clr.
  - A channel acked in the current cycle is masked, so it is served at most once per two cycles.
  - This masking prevents double counting while the requester drops req.
- Arbitration, when pause=0 and the eligible set is non-zero:
  - Pick the first eligible channel searching upward from last_grant+1, modulo 3.
  - Priority order from last_grant=0 is 1,2,0; from 1 is 2,0,1; from 2 is 0,1,2.
- Grant of channel g at edge t→t+1:
  - count_g ← count_g + step_g.
  - ack[g] = 1 for exactly cycle t+1; all other ack bits = 0.
  - last_grant ← g.
- No grant (pause=1, or nothing eligible): ack = 0 next cycle; counters, pointer and ovf hold.
- Arithmetic: the step is zero-extended to WIDTH+1 bits, and the sum is formed in WIDTH+1 bits.
  - Carry out sets ovf[g], which stays set.
  - SATURATE=0: the result is the low WIDTH bits.
  - SATURATE=1: the result is 2^WIDTH-1.
  - step=0 is legal: the counter is unchanged and ack is still issued.
- Clear: clr[i]=1 sets count_i to 0 and ovf[i] to 0 at the next edge.
  - The channel is masked from arbitration that cycle, so no ack.
  - Other channels arbitrate normally in the same cycle.
- Simultaneous clr on all channels: no grant; last_grant holds.
- pause has no effect on clr.
- req dropped before its grant: no increment and no ack. No request is stored internally.

## Timing
- Latency: req and step sampled at edge t; ack and the updated count are both visible in cycle t+1 (one cycle).
- Throughput: one increment per cycle in aggregate.
- Per channel: at most one increment every two cycles.
- Fairness: with all three requests held high, grants rotate 0,1,2,0,… Each channel is served within 3 grants.
- The requester must keep req and step stable until it sees ack. It drops req in the ack cycle unless it wants another increment.
- All outputs are registered; there is no combinational input-to-output path.
- Reset asserted mid-operation: any ack due next cycle is suppressed and all state returns to reset values at that edge.

## Test plan
- Reset, then req=3'b111 and steps=1,2,3 held for 6 cycles:
  - ack sequence 001, 010, 100, 001, 010, 100.
  - Final count0=2, count1=4, count2=6.
- Single channel, req[1] held high for 10 cycles with step=5:
  - ack[1] pulses on alternate cycles (5 pulses).
  - count1=25, last_grant=1.
- SATURATE=0, count0 preloaded to 250 via repeated grants, then step=15:
  - count0=9, ovf[0]=1.
  - After clr[0]: count0=0, ovf[0]=0.
  - With SATURATE=1, the same stimulus gives count0=255, ovf[0]=1.
- Pause and clear: req=3'b110 with pause=1 for 4 cycles:
  - No ack, counters unchanged.
  - Release pause with clr[1]=1 on the same cycle: channel 2 is granted first, channel 1 is cleared and not acked.
- Reset mid-operation: assert reset for 1 cycle during a grant stream:
  - Next cycle ack=0, all counts=0, ovf=0.
  - The next grant goes to channel 0.
